// File: rtl/icache_pkg.sv
// Shared types and width/field helpers for the set-associative icache storage.
package icache_pkg;

    typedef enum logic [1:0] {IDLE, FILL, COMMIT} fill_state_t;

    function automatic int calc_tag_width(input int offset_width, input int line_width);
        return 32 - offset_width - line_width - 2;
    endfunction

    function automatic int calc_way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Extracts width bits starting at lsb; callers size-cast the result to the field type.
    function automatic logic [31:0] addr_field(input logic [31:0] a, input int lsb, input int width);
        return (a >> lsb) & ((32'd1 << width) - 32'd1);
    endfunction

    function automatic int word_lsb();
        return 2;
    endfunction

    function automatic int set_lsb(input int offset_width);
        return offset_width + 2;
    endfunction

    function automatic int tag_lsb(input int offset_width, input int line_width);
        return offset_width + line_width + 2;
    endfunction

endpackage

// File: rtl/icache_assoc_array_if.sv
// Fetch lookup, refill and invalidate signals between the miss controller/fetch side and the array.
interface icache_assoc_array_if #(parameter int way_bits = 1);

    logic [31:0]         address;
    logic [31:0]         instruction;
    logic                hit;
    logic [way_bits-1:0] hit_way;
    logic                refill_start;
    logic [31:0]         refill_address;
    logic [31:0]         refill_word;
    logic                refill_word_valid;
    logic                refill_busy;
    logic                refill_done;
    logic                invalidate_line;
    logic [31:0]         invalidate_address;
    logic                invalidate_all;

    modport master (
        output address, refill_start, refill_address, refill_word, refill_word_valid,
               invalidate_line, invalidate_address, invalidate_all,
        input  instruction, hit, hit_way, refill_busy, refill_done
    );

    modport slave (
        input  address, refill_start, refill_address, refill_word, refill_word_valid,
               invalidate_line, invalidate_address, invalidate_all,
        output instruction, hit, hit_way, refill_busy, refill_done
    );

endinterface

// File: rtl/plru_tree.sv
// Combinational tree-PLRU: marks an accessed way MRU and reports the current victim.
module plru_tree
    import icache_pkg::*;
#(
    parameter  int ways      = 2,
    localparam int way_bits  = calc_way_bits(ways),
    localparam int plru_bits = (ways > 1) ? ways - 1 : 1
) (
    input  logic [plru_bits-1:0] bits_in,
    input  logic [way_bits-1:0]  access,
    output logic [plru_bits-1:0] bits_out,
    output logic [way_bits-1:0]  victim
);

    localparam int levels = (ways > 1) ? $clog2(ways) : 0;

    // Node n has children 2n+1 (left) and 2n+2 (right); a node bit points at the LRU side.
    always_comb begin
        int   node;
        logic d;
        bits_out = bits_in;
        victim   = '0;
        d        = 1'b0;
        node     = 0;
        for (int l = 0; l < levels; l++) begin
            d              = access[levels-1-l];
            bits_out[node] = ~d;
            node           = 2 * node + 1 + int'(d);
        end
        node = 0;
        for (int l = 0; l < levels; l++) begin
            d                   = bits_in[node];
            victim[levels-1-l]  = d;
            node                = 2 * node + 1 + int'(d);
        end
    end

endmodule

// File: rtl/icache_assoc_array.sv
// N-way set-associative icache storage: registered lookup, word-serial refill, PLRU, invalidation.
module icache_assoc_array
    import icache_pkg::*;
#(
    parameter int offset_width = 2,
    parameter int line_width   = 6,
    parameter int ways         = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    icache_assoc_array_if.slave   bus
);

    localparam int tag_width  = calc_tag_width(offset_width, line_width);
    localparam int block_size = 1 << offset_width;
    localparam int way_bits   = calc_way_bits(ways);
    localparam int sets       = 1 << line_width;
    localparam int word_bits  = (offset_width > 0) ? offset_width : 1;
    localparam int plru_bits  = (ways > 1) ? ways - 1 : 1;

    typedef logic [line_width-1:0] set_t;
    typedef logic [tag_width-1:0]  tag_t;
    typedef logic [word_bits-1:0]  word_t;
    typedef logic [way_bits-1:0]   way_t;
    typedef logic [plru_bits-1:0]  plru_t;

    tag_t           tag_mem  [ways][sets];
    logic [31:0]    data_mem [ways][sets][block_size];
    logic [ways-1:0] valid_q [sets];
    plru_t          plru_q   [sets];
    logic [31:0]    staging  [block_size];

    fill_state_t state_q, state_next;
    word_t       beat_count;
    tag_t        fill_tag;
    set_t        fill_set;
    way_t        fill_way;

    logic        hit_q;
    way_t        hit_way_q;
    logic [31:0] instruction_q;
    logic        done_q;

    set_t  lk_set, rf_set, inv_set;
    tag_t  lk_tag, rf_tag, inv_tag;
    word_t lk_word;
    logic  lk_hit;
    way_t  lk_way;
    way_t  victim, plru_victim;
    plru_t hit_plru_next, commit_plru_in, commit_plru_next;
    logic  accept_start, commit;

    assign lk_set  = set_t'(addr_field(bus.address, set_lsb(offset_width), line_width));
    assign lk_tag  = tag_t'(addr_field(bus.address, tag_lsb(offset_width, line_width), tag_width));
    assign lk_word = word_t'(addr_field(bus.address, word_lsb(), offset_width));
    assign rf_set  = set_t'(addr_field(bus.refill_address, set_lsb(offset_width), line_width));
    assign rf_tag  = tag_t'(addr_field(bus.refill_address, tag_lsb(offset_width, line_width), tag_width));
    assign inv_set = set_t'(addr_field(bus.invalidate_address, set_lsb(offset_width), line_width));
    assign inv_tag = tag_t'(addr_field(bus.invalidate_address, tag_lsb(offset_width, line_width), tag_width));

    assign accept_start = (state_q == IDLE) && bus.refill_start;
    assign commit       = (state_q == COMMIT);

    // Descending scan so the lowest matching way wins.
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int w = ways - 1; w >= 0; w--) begin
            if (valid_q[lk_set][w] && (tag_mem[w][lk_set] == lk_tag)) begin
                lk_hit = 1'b1;
                lk_way = way_t'(w);
            end
        end
    end

    always_comb begin
        logic found;
        found  = 1'b0;
        victim = plru_victim;
        for (int w = 0; w < ways; w++) begin
            if (!found && !valid_q[rf_set][w]) begin
                victim = way_t'(w);
                found  = 1'b1;
            end
        end
    end

    // A hit and a commit landing on the same set both apply, commit last.
    assign commit_plru_in = (lk_hit && (lk_set == fill_set)) ? hit_plru_next : plru_q[fill_set];

    plru_tree #(.ways(ways)) u_plru_hit (
        .bits_in (plru_q[lk_set]),
        .access  (lk_way),
        .bits_out(hit_plru_next),
        .victim  ()
    );

    plru_tree #(.ways(ways)) u_plru_commit (
        .bits_in (commit_plru_in),
        .access  (fill_way),
        .bits_out(commit_plru_next),
        .victim  ()
    );

    plru_tree #(.ways(ways)) u_plru_victim (
        .bits_in (plru_q[rf_set]),
        .access  ('0),
        .bits_out(),
        .victim  (plru_victim)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (bus.refill_start) state_next = FILL;
            FILL:    if (bus.refill_word_valid && (beat_count == word_t'(block_size - 1)))
                         state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.invalidate_all) state_next = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset || bus.invalidate_all) begin
            valid_q    <= '{default: '0};
            plru_q     <= '{default: '0};
            hit_q      <= 1'b0;
            hit_way_q  <= '0;
            done_q     <= 1'b0;
            beat_count <= '0;
            if (reset) instruction_q <= '0;
        end else begin
            hit_q     <= lk_hit;
            hit_way_q <= lk_hit ? lk_way : '0;
            if (lk_hit) instruction_q <= data_mem[lk_way][lk_set][lk_word];
            done_q <= commit;

            if (ways > 1) begin
                if (lk_hit) plru_q[lk_set]   <= hit_plru_next;
                if (commit) plru_q[fill_set] <= commit_plru_next;
            end

            if (accept_start)                                beat_count <= '0;
            else if ((state_q == FILL) && bus.refill_word_valid) beat_count <= beat_count + 1'b1;

            // Invalidate first so a same-edge commit to that way leaves it valid.
            if (bus.invalidate_line) begin
                for (int w = 0; w < ways; w++) begin
                    if (valid_q[inv_set][w] && (tag_mem[w][inv_set] == inv_tag))
                        valid_q[inv_set][w] <= 1'b0;
                end
            end
            if (accept_start) valid_q[rf_set][victim]     <= 1'b0;
            if (commit)       valid_q[fill_set][fill_way] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (accept_start) begin
            fill_tag <= rf_tag;
            fill_set <= rf_set;
            fill_way <= victim;
        end
        if ((state_q == FILL) && bus.refill_word_valid) staging[beat_count] <= bus.refill_word;
        if (commit) begin
            tag_mem[fill_way][fill_set] <= fill_tag;
            for (int i = 0; i < block_size; i++) data_mem[fill_way][fill_set][i] <= staging[i];
        end
    end

    assign bus.instruction = instruction_q;
    assign bus.hit         = hit_q;
    assign bus.hit_way     = hit_way_q;
    assign bus.refill_busy = (state_q != IDLE);
    assign bus.refill_done = done_q;

endmodule

// File: tb/tb_icache_assoc_array.sv
// Directed bench for icache_assoc_array with default parameters (4 words/block, 64 sets, 2 ways).
module tb_icache_assoc_array;

    localparam logic [31:0] park_addr = 32'h0000_FFF0;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    icache_assoc_array_if #(.way_bits(1)) bus ();

    icache_assoc_array #(.offset_width(2), .line_width(6), .ways(2)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic lookup(input string tag, input logic [31:0] addr, input logic exp_hit,
                          input logic [31:0] exp_instr, input logic exp_way);
        bus.address = addr;
        tick();
        chk({tag, "_hit"}, 32'(bus.hit), 32'(exp_hit));
        if (exp_hit) begin
            chk({tag, "_instr"}, bus.instruction, exp_instr);
            chk({tag, "_way"}, 32'(bus.hit_way), 32'(exp_way));
        end
        bus.address = park_addr;
    endtask

    task automatic refill(input string tag, input logic [31:0] addr, input logic [31:0] base);
        bus.refill_start   = 1'b1;
        bus.refill_address = addr;
        tick();
        bus.refill_start = 1'b0;
        chk({tag, "_busy_fill"}, 32'(bus.refill_busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus.refill_word       = base + 32'(i);
            bus.refill_word_valid = 1'b1;
            tick();
        end
        bus.refill_word_valid = 1'b0;
        chk({tag, "_busy_commit"}, 32'(bus.refill_busy), 32'd1);
        chk({tag, "_done_early"}, 32'(bus.refill_done), 32'd0);
        tick();
        chk({tag, "_done"}, 32'(bus.refill_done), 32'd1);
        chk({tag, "_busy_end"}, 32'(bus.refill_busy), 32'd0);
        tick();
        chk({tag, "_done_once"}, 32'(bus.refill_done), 32'd0);
    endtask

    initial begin
        reset                  = 1'b1;
        bus.address            = park_addr;
        bus.refill_start       = 1'b0;
        bus.refill_address     = '0;
        bus.refill_word        = '0;
        bus.refill_word_valid  = 1'b0;
        bus.invalidate_line    = 1'b0;
        bus.invalidate_address = '0;
        bus.invalidate_all     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_hit", 32'(bus.hit), 32'd0);
        chk("rst_instr", bus.instruction, 32'd0);
        chk("rst_way", 32'(bus.hit_way), 32'd0);
        chk("rst_busy", 32'(bus.refill_busy), 32'd0);
        chk("rst_done", 32'(bus.refill_done), 32'd0);

        // Cold miss then fill
        lookup("cold_miss", 32'h100, 1'b0, 32'h0, 1'b0);
        refill("fill100", 32'h100, 32'hA0);
        lookup("hit104", 32'h104, 1'b1, 32'hA1, 1'b0);

        // Associativity and PLRU: set 0 holds tags of 0x0000, 0x1000, 0x2000
        refill("fill0000", 32'h0000, 32'hB0);
        refill("fill1000", 32'h1000, 32'hC0);
        lookup("hit1000", 32'h1000, 1'b1, 32'hC0, 1'b1);
        lookup("touch0000", 32'h0000, 1'b1, 32'hB0, 1'b0);
        refill("fill2000", 32'h2000, 32'hD0);
        lookup("evicted1000", 32'h1000, 1'b0, 32'h0, 1'b0);
        lookup("hit2008", 32'h2008, 1'b1, 32'hD2, 1'b1);
        lookup("kept000c", 32'h000C, 1'b1, 32'hB3, 1'b0);

        // invalidate_line: 0x2000 way is LRU, so 0x1000 replaces it
        refill("refill1000", 32'h1000, 32'hE0);
        lookup("back1004", 32'h1004, 1'b1, 32'hE1, 1'b1);
        bus.invalidate_line    = 1'b1;
        bus.invalidate_address = 32'h1000;
        tick();
        bus.invalidate_line = 1'b0;
        lookup("inv_miss1000", 32'h1000, 1'b0, 32'h0, 1'b0);
        lookup("inv_keep0008", 32'h0008, 1'b1, 32'hB2, 1'b0);

        // Beats in IDLE do not change contents
        bus.refill_word       = 32'hDEAD_BEEF;
        bus.refill_word_valid = 1'b1;
        tick();
        tick();
        bus.refill_word_valid = 1'b0;
        lookup("idle_beats", 32'h0004, 1'b1, 32'hB1, 1'b0);

        // refill_start during FILL ignored; lookup in COMMIT misses then hits
        bus.refill_start   = 1'b1;
        bus.refill_address = 32'h3000;
        tick();
        bus.refill_address    = 32'h4000;
        bus.refill_word       = 32'hF0;
        bus.refill_word_valid = 1'b1;
        tick();
        bus.refill_start = 1'b0;
        for (int i = 1; i < 4; i++) begin
            bus.refill_word = 32'hF0 + 32'(i);
            tick();
        end
        bus.refill_word_valid = 1'b0;
        chk("ign_busy_commit", 32'(bus.refill_busy), 32'd1);
        bus.address = 32'h3004;
        tick();
        chk("commit_cycle_hit", 32'(bus.hit), 32'd0);
        chk("ign_done", 32'(bus.refill_done), 32'd1);
        tick();
        chk("after_commit_hit", 32'(bus.hit), 32'd1);
        chk("after_commit_instr", bus.instruction, 32'hF1);
        chk("after_commit_way", 32'(bus.hit_way), 32'd1);
        bus.address = park_addr;
        tick();
        chk("ign_busy_idle", 32'(bus.refill_busy), 32'd0);
        lookup("ign_4000", 32'h4000, 1'b0, 32'h0, 1'b0);

        // Abort with invalidate_all after two beats
        bus.refill_start   = 1'b1;
        bus.refill_address = 32'h500;
        tick();
        bus.refill_start      = 1'b0;
        bus.refill_word_valid = 1'b1;
        bus.refill_word       = 32'h11;
        tick();
        bus.refill_word = 32'h12;
        tick();
        bus.refill_word_valid = 1'b0;
        bus.invalidate_all    = 1'b1;
        bus.address           = 32'h0004;
        tick();
        bus.invalidate_all = 1'b0;
        bus.address        = park_addr;
        chk("abort_busy", 32'(bus.refill_busy), 32'd0);
        chk("abort_done", 32'(bus.refill_done), 32'd0);
        chk("abort_hit", 32'(bus.hit), 32'd0);
        tick();
        chk("abort_no_done", 32'(bus.refill_done), 32'd0);
        lookup("abort_miss0000", 32'h0000, 1'b0, 32'h0, 1'b0);
        lookup("abort_miss3004", 32'h3004, 1'b0, 32'h0, 1'b0);
        lookup("abort_miss104", 32'h104, 1'b0, 32'h0, 1'b0);
        refill("fill500", 32'h500, 32'h50);
        lookup("hit50c", 32'h50C, 1'b1, 32'h53, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
